// File: rtl/hamming_serial_decoder_pkg.sv
// Shared Hamming(21,16) definitions: code widths, parity positions, FSM states
// and the codeword-to-data extraction used by both the encoder and the decoder.
package hamming_pkg;

    localparam int CW_W   = 21;
    localparam int DATA_W = 16;
    localparam int SYN_W  = 5;

    // Parity bits sit at the power-of-two positions (index = position - 1).
    localparam int PAR_IDX [SYN_W] = '{0, 1, 3, 7, 15};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FIX
    } ham_state_t;

    function automatic logic is_parity_idx(input int idx);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < SYN_W; j++) begin
            if (PAR_IDX[j] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    // Data bits fill the non-parity indices in ascending order.
    function automatic logic [DATA_W-1:0] ham_extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] m;
        int k;
        m = '0;
        k = 0;
        for (int i = 0; i < CW_W; i++) begin
            if (!is_parity_idx(i)) begin
                m[k] = cw[i];
                k++;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Bit-serial syndrome accumulator: folds one codeword bit and its 1-based
// position into the running 5-bit syndrome per enabled cycle.
module hamming_syndrome_acc
    import hamming_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_bit,
    input  logic [SYN_W-1:0] i_pos,
    output logic [SYN_W-1:0] o_syn
);

    logic [SYN_W-1:0] r_syn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syn <= '0;
        end else if (i_clear) begin
            r_syn <= '0;
        end else if (i_en) begin
            r_syn <= r_syn ^ ({SYN_W{i_bit}} & i_pos);
        end
    end

    assign o_syn = r_syn;

endmodule

// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming(21,16) decoder with single-error correction.
// Optional `uncorrectable` output is enabled by defining HAM_UNCORR_FLAG_EN.
module hamming_serial_decoder
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CW_W-1:0]   i_e_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_m_out,
    output logic [SYN_W-1:0]  o_err_pos,
    output logic              o_corrected
`ifdef HAM_UNCORR_FLAG_EN
    ,
    output logic              o_uncorrectable
`endif
);

    ham_state_t        r_state;
    logic [CW_W-1:0]   r_cw;
    logic [SYN_W-1:0]  r_pos;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_m_out;
    logic [SYN_W-1:0]  r_err_pos;
    logic              r_corrected;
`ifdef HAM_UNCORR_FLAG_EN
    logic              r_uncorrectable;
`endif

    logic              w_clear;
    logic              w_acc_en;
    logic              w_bit;
    logic [SYN_W-1:0]  w_syn;
    logic [CW_W-1:0]   w_flip_mask;
    logic              w_flip;
    logic [CW_W-1:0]   w_fixed_cw;

    assign w_clear  = (r_state == ST_IDLE) && i_start;
    assign w_acc_en = (r_state == ST_SCAN);
    assign w_bit    = r_cw[r_pos - 5'd1];

    hamming_syndrome_acc u_syn_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_en    (w_acc_en),
        .i_bit   (w_bit),
        .i_pos   (r_pos),
        .o_syn   (w_syn)
    );

    // One-hot flip mask; syndromes 0 and 22..31 match no position and flip nothing.
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_flip
        assign w_flip_mask[gi] = (w_syn == SYN_W'(gi + 1));
    end

    assign w_flip     = |w_flip_mask;
    assign w_fixed_cw = r_cw ^ w_flip_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cw            <= '0;
            r_pos           <= 5'd1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_m_out         <= '0;
            r_err_pos       <= '0;
            r_corrected     <= 1'b0;
`ifdef HAM_UNCORR_FLAG_EN
            r_uncorrectable <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cw    <= i_e_in;
                        r_pos   <= 5'd1;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_pos == SYN_W'(CW_W)) begin
                        r_pos   <= 5'd1;
                        r_state <= ST_FIX;
                    end else begin
                        r_pos <= r_pos + 5'd1;
                    end
                end
                ST_FIX: begin
                    r_m_out         <= ham_extract(w_fixed_cw);
                    r_err_pos       <= w_syn;
                    r_corrected     <= w_flip;
`ifdef HAM_UNCORR_FLAG_EN
                    r_uncorrectable <= (w_syn > SYN_W'(CW_W));
`endif
                    r_done          <= 1'b1;
                    r_busy          <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_m_out         = r_m_out;
    assign o_err_pos       = r_err_pos;
    assign o_corrected     = r_corrected;
`ifdef HAM_UNCORR_FLAG_EN
    assign o_uncorrectable = r_uncorrectable;
`endif

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed self-checking bench for hamming_serial_decoder (HAM_UNCORR_FLAG_EN optional).
module tb_hamming_serial_decoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [20:0] e_in;
    logic        busy;
    logic        done;
    logic [15:0] m_out;
    logic [4:0]  err_pos;
    logic        corrected;
`ifdef HAM_UNCORR_FLAG_EN
    logic        uncorrectable;
`endif

    int errors = 0;
    int checks = 0;

    hamming_serial_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_e_in      (e_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_m_out     (m_out),
        .o_err_pos   (err_pos),
        .o_corrected (corrected)
`ifdef HAM_UNCORR_FLAG_EN
        ,
        .o_uncorrectable (uncorrectable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_m"}, m_out, 0);
        chk({tag, "_err"}, err_pos, 0);
        chk({tag, "_corr"}, corrected, 0);
`ifdef HAM_UNCORR_FLAG_EN
        chk({tag, "_unc"}, uncorrectable, 0);
`endif
    endtask

    // Called at a negedge; returns at a negedge one cycle after done.
    task automatic decode(input string tag, input logic [20:0] cw,
                          input logic [15:0] exp_m, input logic [4:0] exp_err,
                          input logic exp_corr);
        int lat;
        bit seen;
        start = 1'b1;
        e_in  = cw;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        e_in  = ~cw;
        chk({tag, "_busy"}, busy, 1);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            @(posedge clk); @(negedge clk);
            if (done) seen = 1'b1;
            else lat++;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, lat, 22);
        chk({tag, "_m"}, m_out, exp_m);
        chk({tag, "_err"}, err_pos, exp_err);
        chk({tag, "_corr"}, corrected, exp_corr);
        chk({tag, "_busy_end"}, busy, 0);
`ifdef HAM_UNCORR_FLAG_EN
        chk({tag, "_unc"}, uncorrectable, (exp_err > 5'd21) ? 1 : 0);
`endif
        $display("txn %-10s cw=%06h m=%04h err=%0d corr=%0d lat=%0d",
                 tag, cw, m_out, err_pos, corrected, lat);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_m_hold"}, m_out, exp_m);
    endtask

    initial begin
        int done_cnt;
        int done_edge [3];

        rst_n = 1'b0;
        start = 1'b0;
        e_in  = '0;
        @(negedge clk); @(negedge clk);
        chk_zero_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero_outputs("after_reset");

        decode("clean_ones", 21'h1FFFFE, 16'hFFFF, 5'd0,  1'b0);
        decode("err_p11",    21'h000400, 16'h0000, 5'd11, 1'b1);
        decode("err_p1",     21'h1FFFFF, 16'hFFFF, 5'd1,  1'b1);
        decode("err_p21",    21'h0FFFFE, 16'hFFFF, 5'd21, 1'b1);
        decode("err_p5",     21'h1FFFEE, 16'hFFFF, 5'd5,  1'b1);
        decode("clean_zero", 21'h000000, 16'h0000, 5'd0,  1'b0);
        decode("syn22",      21'h008020, 16'h0004, 5'd22, 1'b0);
        decode("syn31",      21'h00C000, 16'h0400, 5'd31, 1'b0);
        decode("double",     21'h100002, 16'h8000, 5'd23, 1'b0);

        // start held high: accepts at edges 0, 23, 46; each done 22 edges after its start edge
        done_cnt = 0;
        start = 1'b1;
        e_in  = 21'h000400;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                if (done_cnt < 3) done_edge[done_cnt] = t;
                done_cnt++;
            end
            if (t == 46) start = 1'b0;
        end
        chk("b2b_count", done_cnt, 3);
        if (done_cnt >= 3) begin
            chk("b2b_done0", done_edge[0], 22);
            chk("b2b_done1", done_edge[1], 45);
            chk("b2b_done2", done_edge[2], 68);
        end
        chk("b2b_err", err_pos, 11);
        chk("b2b_m", m_out, 0);
        $display("txn %-10s done_pulses=%0d", "b2b", done_cnt);

        // leave nonzero outputs, then reset in the middle of SCAN
        decode("pre_rst", 21'h100002, 16'h8000, 5'd23, 1'b0);
        start = 1'b1;
        e_in  = 21'h1FFFFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_scan_rst");
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); @(negedge clk);
            if (done) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);
        chk_zero_outputs("rst_idle");
        $display("txn %-10s done_pulses=%0d", "rst_abort", done_cnt);

        decode("after_rst", 21'h1FFFEE, 16'hFFFF, 5'd5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
